// File: rtl/nibble_serial_addsub.sv
// Serial adder/subtractor: one 4-bit nibble per clock with a registered carry
// between nibbles, valid/ready handshakes on operand and result sides.
module nibble_serial_addsub #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned N  = WIDTH / 4;
   localparam int unsigned KW = $clog2(N);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sub;
   logic             r_carry;
   logic [KW-1:0]    r_k;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [KW+1:0]    w_base;
   logic [3:0]       w_an;
   logic [3:0]       w_bn;
   logic [3:0]       w_lo;
   logic [4:0]       w_full;
   logic             w_last;

   assign w_base = {r_k, 2'b00};
   assign w_an   = r_a[w_base +: 4];
   assign w_bn   = r_b[w_base +: 4] ^ {4{r_sub}};
   // w_lo[3] is the carry into bit 3 of the nibble, needed for signed overflow
   assign w_lo   = {1'b0, w_an[2:0]} + {1'b0, w_bn[2:0]} + {3'b000, r_carry};
   assign w_full = {1'b0, w_an} + {1'b0, w_bn} + {4'b0000, r_carry};
   assign w_last = (r_k == KW'(N - 1));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_next = S_RUN;
         S_RUN:   if (w_last)    w_next = S_DONE;
         S_DONE:  if (out_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sub   <= 1'b0;
         r_carry <= 1'b0;
         r_k     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_sub   <= sub;
                  r_carry <= sub;
                  r_k     <= '0;
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               r_sum[w_base +: 4] <= w_full[3:0];
               r_carry            <= w_full[4];
               if (w_last) begin
                  r_cout <= w_full[4];
                  r_ovf  <= w_lo[3] ^ w_full[4];
               end else begin
                  r_k <= r_k + KW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign overflow  = r_ovf;

endmodule
